// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_tx serializer.
// Defining PISO_TX_PARITY_EN adds one even-parity bit to each frame.
package piso_pkg;

`ifdef PISO_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int frame_len(input int width);
        return width + (PARITY_EN ? 1 : 0);
    endfunction

    // Counter must reach FLEN itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(frame_len(width) + 1);
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Load/shift register feeding the serializer.
// After a load, out_bit already presents the second bit of the word.
module piso_shreg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             out_bit
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // The first bit goes straight to ser_out at load time, so the register
    // stores the word rotated by one; the wrapped bit is never sent.
    generate
        if (MSB_FIRST) begin : g_msb
            always_comb begin
                sr_d = sr_q;
                if (load) begin
                    sr_d = {d[WIDTH-2:0], d[WIDTH-1]};
                end else if (shift) begin
                    sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
                end
            end
            assign out_bit = sr_q[WIDTH-1];
        end else begin : g_lsb
            always_comb begin
                sr_d = sr_q;
                if (load) begin
                    sr_d = {d[0], d[WIDTH-1:1]};
                end else if (shift) begin
                    sr_d = {sr_q[0], sr_q[WIDTH-1:1]};
                end
            end
            assign out_bit = sr_q[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready input and gapless framing.
// Optional PISO_TX_PARITY_EN appends an even-parity bit after the data bits.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int              FLEN   = frame_len(WIDTH);
    localparam int              CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0]   FLEN_C = CW'(FLEN);
    localparam logic [CW-1:0]   ONE_C  = CW'(1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ser_out_q, ser_out_d;
    logic            ser_valid_q, ser_valid_d;
    logic            frame_start_q, frame_start_d;

    logic            last_cnt;
    logic            accept;
    logic            first_bit;
    logic            sr_shift;
    logic            sr_bit;
    logic            next_bit;

    assign last_cnt  = (cnt_q == FLEN_C);
    assign in_ready  = (state_q == ST_IDLE) || last_cnt;
    assign accept    = in_ready && in_valid;
    assign first_bit = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign sr_shift  = (state_q == ST_SHIFT) && !last_cnt;

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .shift   (sr_shift),
        .d       (in_data),
        .out_bit (sr_bit)
    );

`ifdef PISO_TX_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d = accept ? ^in_data : parity_q;
    // The bit after the last data bit is the stored parity.
    assign next_bit = (cnt_q == CW'(WIDTH)) ? parity_q : sr_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`else
    assign next_bit = sr_bit;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        if (accept) begin
            state_d       = ST_SHIFT;
            cnt_d         = ONE_C;
            ser_out_d     = first_bit;
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
        end else if (state_q == ST_SHIFT) begin
            if (last_cnt) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                ser_out_d   = next_bit;
                ser_valid_d = 1'b1;
                cnt_d       = cnt_q + ONE_C;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB-first and LSB-first instances, WIDTH = 8.
// Expectations switch with PISO_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ready, m_out, m_sv, m_fs, m_busy;
    logic [7:0] l_data = 8'h00;
    logic       l_valid = 1'b0;
    logic       l_ready, l_out, l_sv, l_fs, l_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       e_out;
        logic       e_sv;
        logic       e_fs;
        logic       e_rdy;
    } vec_t;

    vec_t vecs[20];
    int   nvec = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (m_data),
        .in_valid    (m_valid),
        .in_ready    (m_ready),
        .ser_out     (m_out),
        .ser_valid   (m_sv),
        .frame_start (m_fs),
        .busy        (m_busy)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (l_data),
        .in_valid    (l_valid),
        .in_ready    (l_ready),
        .ser_out     (l_out),
        .ser_valid   (l_sv),
        .frame_start (l_fs),
        .busy        (l_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] data, input logic valid, input logic e_out,
                       input logic e_sv, input logic e_fs, input logic e_rdy);
        vecs[nvec].data  = data;
        vecs[nvec].valid = valid;
        vecs[nvec].e_out = e_out;
        vecs[nvec].e_sv  = e_sv;
        vecs[nvec].e_fs  = e_fs;
        vecs[nvec].e_rdy = e_rdy;
        nvec++;
    endtask

    logic [8:0] seq_a;
    logic [8:0] seq_b;

    initial begin
        // Back-to-back table for the MSB-first instance: word 1 then word 2,
        // junk on in_data while not ready, then in_valid drops.
`ifdef PISO_TX_PARITY_EN
        add(8'hA5, 1, 1, 1, 1, 0);
        add(8'hFF, 1, 0, 1, 0, 0);
        add(8'hFF, 1, 1, 1, 0, 0);
        add(8'hFF, 1, 0, 1, 0, 0);
        add(8'hFF, 1, 0, 1, 0, 0);
        add(8'hFF, 1, 1, 1, 0, 0);
        add(8'hFF, 1, 0, 1, 0, 0);
        add(8'hFF, 1, 1, 1, 0, 0);
        add(8'hFF, 1, 0, 1, 0, 1);   // parity of A5 = 0, ready now
        add(8'h07, 1, 0, 1, 1, 0);
        add(8'h55, 1, 0, 1, 0, 0);
        add(8'h55, 1, 0, 1, 0, 0);
        add(8'h55, 1, 0, 1, 0, 0);
        add(8'h55, 1, 0, 1, 0, 0);
        add(8'h55, 1, 1, 1, 0, 0);
        add(8'h55, 1, 1, 1, 0, 0);
        add(8'h55, 1, 1, 1, 0, 0);
        add(8'h55, 1, 1, 1, 0, 1);   // parity of 07 = 1
        add(8'h00, 0, 0, 0, 0, 1);
`else
        add(8'hA5, 1, 1, 1, 1, 0);
        add(8'hFF, 1, 0, 1, 0, 0);
        add(8'hFF, 1, 1, 1, 0, 0);
        add(8'hFF, 1, 0, 1, 0, 0);
        add(8'hFF, 1, 0, 1, 0, 0);
        add(8'hFF, 1, 1, 1, 0, 0);
        add(8'hFF, 1, 0, 1, 0, 0);
        add(8'hFF, 1, 1, 1, 0, 1);   // last bit of A5, ready now
        add(8'h3C, 1, 0, 1, 1, 0);
        add(8'h55, 1, 0, 1, 0, 0);
        add(8'h55, 1, 1, 1, 0, 0);
        add(8'h55, 1, 1, 1, 0, 0);
        add(8'h55, 1, 1, 1, 0, 0);
        add(8'h55, 1, 1, 1, 0, 0);
        add(8'h55, 1, 0, 1, 0, 0);
        add(8'h55, 1, 0, 1, 0, 1);
        add(8'h00, 0, 0, 0, 0, 1);
`endif

        // Reset asserted: outputs must be cleared without any clock edge.
        #3;
        chk("rst_m_out", m_out, 1'b0);
        chk("rst_m_sv", m_sv, 1'b0);
        chk("rst_m_fs", m_fs, 1'b0);
        chk("rst_m_busy", m_busy, 1'b0);
        chk("rst_l_sv", l_sv, 1'b0);
        #9;
        rst_n = 1'b1;

        // Idle for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_ready", m_ready, 1'b1);
            chk("idle_sv", m_sv, 1'b0);
            chk("idle_out", m_out, 1'b0);
            chk("idle_busy", m_busy, 1'b0);
        end
        $display("txn idle: 5 cycles");

        // Table-driven back-to-back frames on the MSB-first instance.
        for (int r = 0; r < nvec; r++) begin
            m_data  = vecs[r].data;
            m_valid = vecs[r].valid;
            step();
            chk($sformatf("tbl%0d_out", r), m_out, vecs[r].e_out);
            chk($sformatf("tbl%0d_sv", r), m_sv, vecs[r].e_sv);
            chk($sformatf("tbl%0d_fs", r), m_fs, vecs[r].e_fs);
            chk($sformatf("tbl%0d_rdy", r), m_ready, vecs[r].e_rdy);
            chk($sformatf("tbl%0d_busy", r), m_busy, vecs[r].e_sv);
        end
        m_valid = 1'b0;
        $display("txn back-to-back: %0d table rows", nvec);

        // LSB-first 01 with FF pending; index i is the i-th bit sent.
        seq_a = 9'b1_0000_0001;
        seq_b = 9'b0_1111_1111;
        l_data  = 8'h01;
        l_valid = 1'b1;
        step();
        chk("lsb01_fs0", l_fs, 1'b1);
        chk("lsb01_bit0", l_out, seq_a[0]);
        chk("lsb01_rdy0", l_ready, 1'b0);
        l_data = 8'hFF;
        for (int i = 1; i < FLEN; i++) begin
            step();
            chk($sformatf("lsb01_bit%0d", i), l_out, seq_a[i]);
            chk($sformatf("lsb01_fs%0d", i), l_fs, 1'b0);
            chk($sformatf("lsb01_rdy%0d", i), l_ready, 1'(i == FLEN - 1));
        end
        step();
        chk("lsbff_fs0", l_fs, 1'b1);
        chk("lsbff_bit0", l_out, seq_b[0]);
        l_valid = 1'b0;
        for (int i = 1; i < FLEN; i++) begin
            step();
            chk($sformatf("lsbff_bit%0d", i), l_out, seq_b[i]);
            chk($sformatf("lsbff_sv%0d", i), l_sv, 1'b1);
        end
        step();
        chk("lsb_end_sv", l_sv, 1'b0);
        chk("lsb_end_rdy", l_ready, 1'b1);
        $display("txn lsb-first: 01 then FF");

        // Reset in the middle of F0, then a clean 0F frame.
        seq_a = 9'b0_0000_1111;
        seq_b = 9'b0_1111_0000;
        m_data  = 8'hF0;
        m_valid = 1'b1;
        step();
        m_valid = 1'b0;
        chk("f0_fs", m_fs, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("f0_bit%0d", i), m_out, seq_a[i]);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_out", m_out, 1'b0);
        chk("midrst_sv", m_sv, 1'b0);
        chk("midrst_busy", m_busy, 1'b0);
        chk("midrst_rdy", m_ready, 1'b1);
        #2;
        rst_n = 1'b1;
        m_data  = 8'h0F;
        m_valid = 1'b1;
        step();
        m_valid = 1'b0;
        chk("0f_fs0", m_fs, 1'b1);
        chk("0f_bit0", m_out, seq_b[0]);
        for (int i = 1; i < FLEN; i++) begin
            step();
            chk($sformatf("0f_bit%0d", i), m_out, seq_b[i]);
            chk($sformatf("0f_fs%0d", i), m_fs, 1'b0);
            chk($sformatf("0f_sv%0d", i), m_sv, 1'b1);
        end
        step();
        chk("0f_end_sv", m_sv, 1'b0);
        chk("0f_end_busy", m_busy, 1'b0);
        $display("txn reset mid-frame: F0 abandoned, 0F sent");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
